// File: rtl/uart_pkg.sv
// Shared UART constants, frame defaults and transmitter state encoding.
// Used by uart_tx today and intended for the matching receiver.
package uart_pkg;

    localparam int unsigned CLK_FREQ_HZ   = 100_000_000;
    localparam int unsigned BAUD          = 115_200;
    localparam int unsigned BAUD_DIV      = CLK_FREQ_HZ / BAUD;

    localparam int unsigned DEF_DATA_BITS = 8;
    localparam int unsigned DEF_STOP_BITS = 1;

    localparam int unsigned STATE_W       = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_SYNC   = 3'd1,
        ST_START  = 3'd2,
        ST_DATA   = 3'd3,
        ST_PARITY = 3'd4,
        ST_STOP   = 3'd5
    } tx_state_t;

    // Unused upper bits must be zero so they do not disturb the XOR.
    function automatic logic parity_bit(input logic [7:0] bits, input logic odd);
        return (^bits) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: takes a word on a valid/ready handshake and shifts it out LSB first,
// one bit per tick_baud period. Define UART_TX_PARITY_EN to insert a parity bit after the data.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS  = DEF_DATA_BITS,
    parameter int unsigned STOP_BITS  = DEF_STOP_BITS
`ifdef UART_TX_PARITY_EN
    ,
    parameter int unsigned PARITY_ODD = 0
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick_baud,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int unsigned      IDX_W    = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    tx_state_t            state;
    tx_state_t            state_nxt;
    logic [DATA_BITS-1:0] shift;
    logic [DATA_BITS-1:0] shift_nxt;
    logic [IDX_W-1:0]     bit_idx;
    logic [IDX_W-1:0]     bit_idx_nxt;
    logic                 stop_cnt;
    logic                 stop_cnt_nxt;
    logic                 tx_nxt;
    logic                 ready_nxt;
    logic                 busy_nxt;
    logic                 done_nxt;
`ifdef UART_TX_PARITY_EN
    logic                 par;
    logic                 par_nxt;
`endif

    // State and output registers; reset forces an idle-high line immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            shift    <= '0;
            bit_idx  <= '0;
            stop_cnt <= 1'b0;
            tx       <= 1'b1;
            tx_ready <= 1'b1;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par      <= 1'b0;
`endif
        end else begin
            state    <= state_nxt;
            shift    <= shift_nxt;
            bit_idx  <= bit_idx_nxt;
            stop_cnt <= stop_cnt_nxt;
            tx       <= tx_nxt;
            tx_ready <= ready_nxt;
            tx_busy  <= busy_nxt;
            tx_done  <= done_nxt;
`ifdef UART_TX_PARITY_EN
            par      <= par_nxt;
`endif
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt    = state;
        shift_nxt    = shift;
        bit_idx_nxt  = bit_idx;
        stop_cnt_nxt = stop_cnt;
        tx_nxt       = tx;
        done_nxt     = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_nxt      = par;
`endif

        unique case (state)
            ST_IDLE: begin
                tx_nxt = 1'b1;
                // A tick in the handshake cycle is deliberately not acted on.
                if (tx_valid && tx_ready) begin
                    shift_nxt = tx_data;
                    state_nxt = ST_SYNC;
`ifdef UART_TX_PARITY_EN
                    par_nxt   = parity_bit(8'(tx_data), PARITY_ODD != 0);
`endif
                end
            end

            // Wait for a fresh tick so the start bit spans a whole bit period.
            ST_SYNC: begin
                if (tick_baud) begin
                    state_nxt = ST_START;
                    tx_nxt    = 1'b0;
                end
            end

            ST_START: begin
                if (tick_baud) begin
                    state_nxt   = ST_DATA;
                    tx_nxt      = shift[0];
                    bit_idx_nxt = '0;
                end
            end

            ST_DATA: begin
                if (tick_baud) begin
                    if (bit_idx != LAST_IDX) begin
                        shift_nxt   = shift >> 1;
                        tx_nxt      = shift[1];
                        bit_idx_nxt = bit_idx + IDX_W'(1);
                    end else begin
`ifdef UART_TX_PARITY_EN
                        state_nxt    = ST_PARITY;
                        tx_nxt       = par;
`else
                        state_nxt    = ST_STOP;
                        tx_nxt       = 1'b1;
                        stop_cnt_nxt = 1'b0;
`endif
                    end
                end
            end

`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (tick_baud) begin
                    state_nxt    = ST_STOP;
                    tx_nxt       = 1'b1;
                    stop_cnt_nxt = 1'b0;
                end
            end
`endif

            ST_STOP: begin
                if (tick_baud) begin
                    if (STOP_BITS == 2 && stop_cnt == 1'b0) begin
                        stop_cnt_nxt = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                        done_nxt  = 1'b1;
                    end
                end
            end

            default: begin
                state_nxt = ST_IDLE;
                tx_nxt    = 1'b1;
            end
        endcase

        // Handshake flags follow the registered state so they change with it.
        ready_nxt = (state_nxt == ST_IDLE);
        busy_nxt  = (state_nxt != ST_IDLE);
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: two configurations (8N1 and 7 data / 2 stop bits),
// with frames checked against a bit-list model of the UART frame.
`timescale 1ns/1ps
module tb_uart_tx;
    import uart_pkg::*;

`ifdef UART_TX_PARITY_EN
    localparam int P_EN = 1;
`else
    localparam int P_EN = 0;
`endif
    localparam int DB0 = 8, SB0 = 1, ODD0 = 0;
    localparam int DB1 = 7, SB1 = 2, ODD1 = 1;

    typedef struct {
        logic [15:0] bits;
        int          n;
        bit          stable, sync_high, timeout;
        bit          rdy_acc, busy_acc, done_acc, acc_tick;
        bit          done_rdy, done_busy, done_tx;
        int          t_acc, t_sync, t_ph1, t_fall, t_done;
    } cap_t;

    logic       clk  = 1'b0;
    logic       rst  = 1'b0;
    logic       tick = 1'b0;
    logic       valid_s [2];
    logic [7:0] data_s  [2];
    logic       ready_s [2];
    logic       tx_s    [2];
    logic       busy_s  [2];
    logic       done_s  [2];

    int cyc = 0;
    int tcnt = 0;
    int tick_period = 16;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in for baud_gen: one-clk strobe every tick_period clocks, changed on negedge.
    always @(negedge clk) begin
        if (tcnt >= tick_period - 1) begin
            tick <= 1'b1;
            tcnt <= 0;
        end else begin
            tick <= 1'b0;
            tcnt <= tcnt + 1;
        end
    end

    uart_tx #(
        .DATA_BITS (DB0),
        .STOP_BITS (SB0)
`ifdef UART_TX_PARITY_EN
        ,
        .PARITY_ODD(ODD0)
`endif
    ) dut0 (
        .clk      (clk),
        .rst      (rst),
        .tick_baud(tick),
        .tx_data  (data_s[0]),
        .tx_valid (valid_s[0]),
        .tx_ready (ready_s[0]),
        .tx       (tx_s[0]),
        .tx_busy  (busy_s[0]),
        .tx_done  (done_s[0])
    );

    uart_tx #(
        .DATA_BITS (DB1),
        .STOP_BITS (SB1)
`ifdef UART_TX_PARITY_EN
        ,
        .PARITY_ODD(ODD1)
`endif
    ) dut1 (
        .clk      (clk),
        .rst      (rst),
        .tick_baud(tick),
        .tx_data  (data_s[1][DB1-1:0]),
        .tx_valid (valid_s[1]),
        .tx_ready (ready_s[1]),
        .tx       (tx_s[1]),
        .tx_busy  (busy_s[1]),
        .tx_done  (done_s[1])
    );

    // Reference frame: start 0, data LSB first, optional parity, stop 1s. Returns bit count.
    function automatic int exp_frame(input logic [7:0] data, input int db, input int sb,
                                     input int odd, output logic [15:0] bits);
        int ones = 0;
        int k = 1;
        bits = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < db; i++) begin
            bits[k] = data[i];
            ones += int'(data[i]);
            k++;
        end
        if (P_EN != 0) begin
            bits[k] = 1'((ones + odd) % 2);
            k++;
        end
        return k + sb;
    endfunction

    // Drive one handshake on DUT d and record what the line does until tx_done.
    task automatic capture(input int d, input logic [7:0] data, input bit armed, input bit align,
                           input bit hold, input logic [7:0] next_data, output cap_t c);
        int   budget;
        int   phase;
        logic t;
        c.bits = '1; c.n = 0; c.stable = 1'b1; c.sync_high = 1'b1; c.timeout = 1'b0;
        c.done_rdy = 1'b0; c.done_busy = 1'b1; c.done_tx = 1'b0;
        c.t_sync = -1; c.t_ph1 = -1; c.t_fall = -1; c.t_done = -1;
        if (!armed) begin
            budget = 0;
            do begin @(negedge clk); #1; budget++; end
            while (ready_s[d] !== 1'b1 && budget < 5000);
            if (align) begin
                budget = 0;
                while (tick !== 1'b1 && budget < 5000) begin @(negedge clk); #1; budget++; end
            end
            valid_s[d] = 1'b1;
            data_s[d]  = data;
        end
        @(posedge clk);
        c.acc_tick = tick;
        #1;
        c.t_acc = cyc; c.rdy_acc = ready_s[d]; c.busy_acc = busy_s[d]; c.done_acc = done_s[d];
        if (hold) data_s[d] = next_data;
        else begin valid_s[d] = 1'b0; data_s[d] = 8'($urandom); end
        phase  = -1;
        budget = 20 * tick_period + 40;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            t = tick;
            #1;
            if (t === 1'b1) begin
                phase++;
                if (phase == 0) c.t_sync = cyc;
                if (phase == 1) c.t_ph1 = cyc;
            end
            if (c.t_fall < 0 && tx_s[d] === 1'b0) c.t_fall = cyc;
            if (done_s[d] === 1'b1) begin
                c.t_done = cyc; c.n = phase;
                c.done_rdy = ready_s[d]; c.done_busy = busy_s[d]; c.done_tx = tx_s[d];
                break;
            end
            if (phase < 0) begin
                if (tx_s[d] !== 1'b1) c.sync_high = 1'b0;
            end else if (phase < 16) begin
                if (t === 1'b1) c.bits[phase] = tx_s[d];
                else if (tx_s[d] !== c.bits[phase]) c.stable = 1'b0;
            end
        end
        if (c.t_done < 0) c.timeout = 1'b1;
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            n_cmp++; if (tx_s[d] !== 1'b1) begin n_bad++; $display("FAIL reset_tx[%0d]: got %b want 1", d, tx_s[d]); end
            n_cmp++; if (ready_s[d] !== 1'b1) begin n_bad++; $display("FAIL reset_ready[%0d]: got %b want 1", d, ready_s[d]); end
            n_cmp++; if (busy_s[d] !== 1'b0) begin n_bad++; $display("FAIL reset_busy[%0d]: got %b want 0", d, busy_s[d]); end
            n_cmp++; if (done_s[d] !== 1'b0) begin n_bad++; $display("FAIL reset_done[%0d]: got %b want 0", d, done_s[d]); end
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        cap_t c;
        logic [15:0] eb;
        int n;
        tick_period = int'(BAUD_DIV);
        n = exp_frame(8'h55, DB0, SB0, ODD0, eb);
        capture(0, 8'h55, 1'b0, 1'b0, 1'b0, 8'h00, c);
        n_cmp++; if (c.rdy_acc !== 1'b0) begin n_bad++; $display("FAIL basic_ready_drop: got %b want 0", c.rdy_acc); end
        n_cmp++; if (c.busy_acc !== 1'b1) begin n_bad++; $display("FAIL basic_busy: got %b want 1", c.busy_acc); end
        n_cmp++; if (c.timeout !== 1'b0) begin n_bad++; $display("FAIL basic_timeout: no tx_done within budget"); end
        n_cmp++; if (c.sync_high !== 1'b1) begin n_bad++; $display("FAIL basic_sync_idle: tx left idle-high before first tick"); end
        n_cmp++; if (c.t_sync - c.t_acc < 1 || c.t_sync - c.t_acc > tick_period) begin n_bad++; $display("FAIL basic_sync_wait: got %0d want 1..%0d", c.t_sync - c.t_acc, tick_period); end
        n_cmp++; if (c.t_fall !== c.t_sync) begin n_bad++; $display("FAIL basic_latency: tx fell at %0d want %0d", c.t_fall, c.t_sync); end
        n_cmp++; if (c.bits !== eb) begin n_bad++; $display("FAIL basic_bits: got %h want %h", c.bits, eb); end
        n_cmp++; if (c.n !== n) begin n_bad++; $display("FAIL basic_nbits: got %0d want %0d", c.n, n); end
        n_cmp++; if (c.stable !== 1'b1) begin n_bad++; $display("FAIL basic_bit_hold: tx changed inside a bit period"); end
        n_cmp++; if (c.t_done - c.t_sync !== n * tick_period) begin n_bad++; $display("FAIL basic_frame_len: got %0d want %0d", c.t_done - c.t_sync, n * tick_period); end
        n_cmp++; if (c.done_rdy !== 1'b1 || c.done_busy !== 1'b0) begin n_bad++; $display("FAIL basic_done_flags: ready %b busy %b want 1 0", c.done_rdy, c.done_busy); end
        @(posedge clk); #1;
        n_cmp++; if (done_s[0] !== 1'b0) begin n_bad++; $display("FAIL basic_done_width: got %b want 0", done_s[0]); end
    endtask

    task automatic test_back_to_back();
        cap_t c1, c2;
        logic [15:0] e1, e2;
        int n1, n2;
        tick_period = int'(BAUD_DIV);
        n1 = exp_frame(8'hA5, DB0, SB0, ODD0, e1);
        n2 = exp_frame(8'h3C, DB0, SB0, ODD0, e2);
        capture(0, 8'hA5, 1'b0, 1'b0, 1'b1, 8'h3C, c1);
        capture(0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, c2);
        n_cmp++; if (c1.timeout !== 1'b0 || c2.timeout !== 1'b0) begin n_bad++; $display("FAIL b2b_timeout: %b %b", c1.timeout, c2.timeout); end
        n_cmp++; if (c1.bits !== e1 || c1.n !== n1) begin n_bad++; $display("FAIL b2b_first: got %h/%0d want %h/%0d", c1.bits, c1.n, e1, n1); end
        n_cmp++; if (c2.bits !== e2 || c2.n !== n2) begin n_bad++; $display("FAIL b2b_second: got %h/%0d want %h/%0d", c2.bits, c2.n, e2, n2); end
        n_cmp++; if (c2.t_acc !== c1.t_done + 1 || c2.rdy_acc !== 1'b0) begin n_bad++; $display("FAIL b2b_accept: at %0d want %0d ready %b", c2.t_acc, c1.t_done + 1, c2.rdy_acc); end
        n_cmp++; if (c2.t_sync - c1.t_done < 1 || c2.t_sync - c1.t_done > tick_period) begin n_bad++; $display("FAIL b2b_gap: got %0d want 1..%0d", c2.t_sync - c1.t_done, tick_period); end
        n_cmp++; if (c1.stable !== 1'b1 || c2.stable !== 1'b1 || c2.sync_high !== 1'b1) begin n_bad++; $display("FAIL b2b_hold: %b %b %b", c1.stable, c2.stable, c2.sync_high); end
    endtask

    task automatic test_tick_coincident();
        cap_t c;
        logic [15:0] eb;
        logic [7:0]  dat;
        int n;
        tick_period = 16;
        dat = 8'($urandom);
        n = exp_frame(dat, DB0, SB0, ODD0, eb);
        capture(0, dat, 1'b0, 1'b1, 1'b0, 8'h00, c);
        n_cmp++; if (c.t_sync - c.t_acc !== 16) begin n_bad++; $display("FAIL coinc_sync_wait: got %0d want 16", c.t_sync - c.t_acc); end
        n_cmp++; if (c.t_ph1 - c.t_sync !== 16 || c.bits[0] !== 1'b0) begin n_bad++; $display("FAIL coinc_start_len: got %0d bit %b want 16 0", c.t_ph1 - c.t_sync, c.bits[0]); end
        n_cmp++; if (c.bits !== eb || c.n !== n || c.timeout !== 1'b0) begin n_bad++; $display("FAIL coinc_frame: got %h/%0d want %h/%0d", c.bits, c.n, eb, n); end
    endtask

    task automatic test_reset_mid_frame();
        cap_t c;
        logic [15:0] eb;
        int n, ticks, budget;
        bit done_seen, tx_low;
        tick_period = 16;
        budget = 0;
        do begin @(negedge clk); #1; budget++; end while (ready_s[0] !== 1'b1 && budget < 5000);
        valid_s[0] = 1'b1; data_s[0] = 8'hFF;
        @(posedge clk); #1;
        valid_s[0] = 1'b0;
        ticks = 0; budget = 0;
        while (ticks < 6 && budget < 400) begin
            @(posedge clk);
            if (tick === 1'b1) ticks++;
            #1; budget++;
        end
        repeat (5) @(posedge clk);
        @(negedge clk); #1;
        n_cmp++; if (busy_s[0] !== 1'b1) begin n_bad++; $display("FAIL rstmid_busy_before: got %b want 1", busy_s[0]); end
        rst = 1'b1;
        #1;
        n_cmp++; if (tx_s[0] !== 1'b1) begin n_bad++; $display("FAIL rstmid_tx: got %b want 1", tx_s[0]); end
        n_cmp++; if (busy_s[0] !== 1'b0 || ready_s[0] !== 1'b1) begin n_bad++; $display("FAIL rstmid_flags: busy %b ready %b want 0 1", busy_s[0], ready_s[0]); end
        done_seen = (done_s[0] === 1'b1);
        tx_low = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (done_s[0] !== 1'b0) done_seen = 1'b1;
            if (tx_s[0] !== 1'b1) tx_low = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done_s[0] !== 1'b0) done_seen = 1'b1;
            if (tx_s[0] !== 1'b1) tx_low = 1'b1;
        end
        n_cmp++; if (done_seen !== 1'b0) begin n_bad++; $display("FAIL rstmid_no_done: got pulse want none"); end
        n_cmp++; if (tx_low !== 1'b0) begin n_bad++; $display("FAIL rstmid_glitch: got tx low want steady 1"); end
        n = exp_frame(8'h00, DB0, SB0, ODD0, eb);
        capture(0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, c);
        n_cmp++; if (c.bits !== eb || c.n !== n || c.timeout !== 1'b0 || c.stable !== 1'b1) begin n_bad++; $display("FAIL rstmid_next_frame: got %h/%0d want %h/%0d", c.bits, c.n, eb, n); end
        n_cmp++; if (c.t_done - c.t_sync !== n * tick_period) begin n_bad++; $display("FAIL rstmid_frame_len: got %0d want %0d", c.t_done - c.t_sync, n * tick_period); end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        cap_t c;
        tick_period = 16;
        capture(0, 8'h07, 1'b0, 1'b0, 1'b0, 8'h00, c);
        n_cmp++; if (c.bits[9] !== 1'b1) begin n_bad++; $display("FAIL parity_even: got %b want 1", c.bits[9]); end
        n_cmp++; if (c.n !== 11 || c.t_done - c.t_sync !== 11 * 16) begin n_bad++; $display("FAIL parity_len: got %0d bits %0d clk want 11 176", c.n, c.t_done - c.t_sync); end
        capture(1, 8'h07, 1'b0, 1'b0, 1'b0, 8'h00, c);
        n_cmp++; if (c.bits[8] !== 1'b0) begin n_bad++; $display("FAIL parity_odd: got %b want 0", c.bits[8]); end
    endtask
`endif

    task automatic test_two_stop();
        cap_t c;
        logic [15:0] eb;
        int n;
        tick_period = 16;
        n = exp_frame(8'h41, DB1, SB1, ODD1, eb);
        capture(1, 8'h41, 1'b0, 1'b0, 1'b0, 8'h00, c);
        n_cmp++; if (c.n !== 10 + P_EN || c.n !== n) begin n_bad++; $display("FAIL stop2_nbits: got %0d want %0d", c.n, 10 + P_EN); end
        n_cmp++; if (c.bits !== eb || c.stable !== 1'b1) begin n_bad++; $display("FAIL stop2_bits: got %h want %h", c.bits, eb); end
        n_cmp++; if (c.bits[n-1] !== 1'b1 || c.bits[n-2] !== 1'b1) begin n_bad++; $display("FAIL stop2_high: got %b%b want 11", c.bits[n-2], c.bits[n-1]); end
        n_cmp++; if (c.t_done - c.t_sync !== n * 16 || c.timeout !== 1'b0) begin n_bad++; $display("FAIL stop2_len: got %0d want %0d", c.t_done - c.t_sync, n * 16); end
    endtask

    task automatic test_random();
        cap_t c;
        logic [15:0] eb;
        logic [7:0]  dat, nd, sent;
        int d, n, db, sb, odd;
        bit armed, hold;
        armed = 1'b0; d = 0; nd = 8'h00;
        for (int i = 0; i < 24; i++) begin
            if (!armed) begin
                d = int'($urandom_range(0, 1));
                tick_period = int'($urandom_range(6, 20));
                repeat ($urandom_range(0, 5)) @(negedge clk);
            end
            dat  = 8'($urandom);
            sent = armed ? nd : dat;
            nd   = 8'($urandom);
            hold = ($urandom_range(0, 2) == 0) && (i < 23);
            db   = (d == 0) ? DB0 : DB1;
            sb   = (d == 0) ? SB0 : SB1;
            odd  = (d == 0) ? ODD0 : ODD1;
            n = exp_frame(sent, db, sb, odd, eb);
            capture(d, dat, armed, 1'b0, hold, nd, c);
            armed = hold;
            n_cmp++; if (c.bits !== eb || c.n !== n) begin n_bad++; $display("FAIL rand_frame[%0d] d%0d data %h: got %h/%0d want %h/%0d", i, d, sent, c.bits, c.n, eb, n); end
            n_cmp++; if (c.stable !== 1'b1 || c.sync_high !== 1'b1 || c.timeout !== 1'b0) begin n_bad++; $display("FAIL rand_line[%0d]: hold %b idle %b timeout %b", i, c.stable, c.sync_high, c.timeout); end
            n_cmp++; if (c.t_done - c.t_sync !== n * tick_period || c.done_acc !== 1'b0) begin n_bad++; $display("FAIL rand_len[%0d]: got %0d want %0d", i, c.t_done - c.t_sync, n * tick_period); end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        valid_s[0] = 1'b0; valid_s[1] = 1'b0;
        data_s[0]  = 8'h00; data_s[1] = 8'h00;
        test_reset();
        test_basic();
        test_back_to_back();
        test_tick_coincident();
        test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        test_two_stop();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial UART transmitter, 8N1 by default, LSB first.
- Consumes the one-cycle `tick_baud` strobe from the team's baud generator: 100 MHz / 115200, one pulse every 868 clk.
- Accepts bytes via a valid/ready handshake and drives the idle-high serial line `tx` with registered outputs.
- Sits between the host-side byte source and the FPGA TX pin.

Parameters:
- DATA_BITS, 8, data bits per frame; legal 5..8.
- STOP_BITS, 1, stop bits per frame; legal 1 or 2.
- PARITY_ODD, 0, parity sense when the parity feature is compiled in: 0 = even, 1 = odd.

Ports:
- clk  in  1  100 MHz system clock
- rst  in  1  reset; asynchronous, active-high
- tick_baud  in  1  one-clk bit-period strobe from the baud generator
- tx_data  in  DATA_BITS  byte to send; sampled only on handshake
- tx_valid  in  1  source has data
- tx_ready  out  1  block can accept; high only in IDLE
- tx  out  1  serial line, idle high, registered
- tx_busy  out  1  high in every state except IDLE
- tx_done  out  1  one-clk pulse when the final stop bit completes

Behaviour:
- Reset:
  - Asynchronous, active-high: state=IDLE, tx=1, tx_done=0, shift register and counters cleared.
  - tx_ready=1 and tx_busy=0 while in reset.
  - Reset mid-frame aborts the frame immediately; tx returns high with no glitch to 0.
- States: IDLE, SYNC, START, DATA, PARITY (feature only), STOP.
- IDLE:
  - tx=1.
  - On tx_valid && tx_ready, latch tx_data into the shift register and go to SYNC.
  - A tick_baud in the handshake cycle is ignored.
- SYNC:
  - tx stays 1; waits for the first tick_baud strictly after acceptance.
  - On that tick: go to START, tx=0 from the next clk.
  - This aligns the start bit to a full bit period.
- START: on tick → DATA, tx=shift[0], bit_idx=0.
- DATA:
  - On tick, if bit_idx<DATA_BITS-1: shift right, tx=next bit, bit_idx++.
  - Otherwise go to PARITY (feature) or STOP with tx=1, stop_cnt=0.
- STOP:
  - On tick, if stop_cnt<STOP_BITS-1: stop_cnt++.
  - Otherwise go to IDLE and pulse tx_done for one clk, in the same cycle tx_ready rises.
- Bit period: every bit is held exactly one tick-to-tick interval (868 clk with the standard divisor).
  - Frame length from the SYNC tick to the final STOP tick = (1+DATA_BITS+P+STOP_BITS) tick periods, where P=1 with parity, else 0.
- Latency:
  - tx falls 1 clk after the first tick following acceptance.
  - Worst case from acceptance to tx falling is one bit period + 1 clk.
- Back-to-back frames: the next byte can be accepted in the cycle after tx_done. The SYNC wait inserts 0..1 bit period of extra idle-high between frames; this is legal UART.
- Ignored inputs:
  - tx_valid while busy is ignored and must be held by the source.
  - tx_data changes mid-frame have no effect.
- tick_baud outside SYNC/START/DATA/PARITY/STOP is ignored.
- Counters: bit_idx is $clog2(DATA_BITS) wide and stop_cnt is 1 bit. Neither wraps; both are reloaded on state entry.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: the PARITY state is inserted after DATA. tx = XOR of the latched data bits, inverted if PARITY_ODD=1. It is held for one tick period, then the block enters STOP.
- Undefined: no PARITY state, no parity logic, and PARITY_ODD is unused. The frame is 8N1 (with defaults).

Decomposition:
- Package uart_pkg holds:
  - CLK_FREQ_HZ=100_000_000, BAUD=115200, BAUD_DIV=868
  - the state enum typedef tx_state_t
  - default DATA_BITS/STOP_BITS constants, shared with the future receiver
- No sub-module: the shift register, counters and FSM stay in one module. baud_gen is instantiated alongside, not inside.

Test Plan:
1. Send 0x55 with baud_gen (868 clk/bit): tx_valid=1 at cycle A → tx_ready drops at A+1. After the next tick, tx shows 0,1,0,1,0,1,0,1,0,1, each held 868 clk. tx_done pulses once, exactly 10×868 clk after the SYNC tick.
2. Back-to-back 0xA5 then 0x3C with tx_valid held: second accept occurs the cycle after the first tx_done. Check the idle gap ≤868 clk and both frames decode correctly (LSB first).
3. Tick coincident with handshake (bench-driven tick, period 16 clk): the coincident tick is ignored. The start bit begins after the following tick and lasts exactly 16 clk.
4. Assert rst for 3 clk during DATA bit 4 of 0xFF: tx=1 within the reset cycle, tx_busy=0, tx_done never pulses. The next byte 0x00 transmits cleanly.
5. With UART_TX_PARITY_EN, PARITY_ODD=0: 0x07 → parity bit 1. With PARITY_ODD=1 → 0. Frame is 11 bit periods.
6. STOP_BITS=2, DATA_BITS=7, byte 0x41: tx holds high for 2 bit periods before tx_done. Frame is 10 bit periods, or 11 with parity.
